// File: rtl/gf180mcu_osu_sc_pkg.sv
// Shared definitions for the gf180mcu_osu_sc pipelined adder family.
//   ADDP_ADD / ADDP_SUB : encodings of the SUB mode input
//   addp_params_ok()    : elaboration-time legality check of WIDTH/STAGES
package gf180mcu_osu_sc_pkg;

   localparam logic ADDP_ADD = 1'b0;
   localparam logic ADDP_SUB = 1'b1;

   // The stages >= 1 term is evaluated first so the modulo never divides by zero.
   function automatic bit addp_params_ok(input int width, input int stages);
      return (width >= 2) && (stages >= 1) && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_12t_addp_seg.sv
// Combinational SEG-bit ripple segment of the pipelined adder.
// Each bit is a full adder built from two half adders and an OR.
//   a, b : segment operands (b already mode-adjusted by the caller)
//   ci   : carry into bit 0
//   s    : segment sum
//   co   : carry out of the segment MSB
//   cm   : carry into the segment MSB (used for signed overflow)
module gf180mcu_osu_sc_12T_addp_seg
   import gf180mcu_osu_sc_pkg::*;
#(
   parameter int SEG = 4
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           ci,
   output logic [SEG-1:0] s,
   output logic           co,
   output logic           cm
);

   logic [SEG:0]   c;
   logic [SEG-1:0] h1_s;
   logic [SEG-1:0] h1_c;
   logic [SEG-1:0] h2_c;

   always_comb begin
      c    = '0;
      s    = '0;
      h1_s = '0;
      h1_c = '0;
      h2_c = '0;
      c[0] = ci;
      for (int i = 0; i < SEG; i++) begin
         h1_s[i]  = a[i] ^ b[i];
         h1_c[i]  = a[i] & b[i];
         s[i]     = h1_s[i] ^ c[i];
         h2_c[i]  = h1_s[i] & c[i];
         c[i+1]   = h1_c[i] | h2_c[i];
      end
   end

   assign co = c[SEG];
   assign cm = c[SEG-1];

endmodule

// File: rtl/gf180mcu_osu_sc_12t_addp.sv
// Pipelined WIDTH-bit adder/subtractor with valid/ready flow control.
// The carry chain is cut into STAGES segments of SEG bits; each segment
// has one register stage. Unprocessed high operand bits are skewed forward
// alongside the partial sum and the inter-segment carry.
//   CLK, RN        : clock, asynchronous active-low reset
//   A, B, CI, SUB  : operands, carry-in, mode (0 add, 1 A + ~B + CI)
//   VLD_I / RDY_O  : input handshake, RDY_O = RDY_I | ~VLD_O
//   S, CO, OV      : result, carry-out, signed overflow (held while VLD_O=0)
//   VLD_O / RDY_I  : output handshake
module gf180mcu_osu_sc_12t_addp
   import gf180mcu_osu_sc_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CI,
   input  logic             SUB,
   input  logic             VLD_I,
   output logic             RDY_O,
   output logic [WIDTH-1:0] S,
   output logic             CO,
   output logic             OV,
   output logic             VLD_O,
   input  logic             RDY_I
);

   localparam int SEG = WIDTH / STAGES;

   if (!addp_params_ok(WIDTH, STAGES)) begin : g_bad_params
      $fatal(1, "addp: illegal WIDTH=%0d STAGES=%0d", WIDTH, STAGES);
   end

   logic             accept;
   logic [WIDTH-1:0] b_eff;

   assign RDY_O  = RDY_I | ~VLD_O;
   assign accept = VLD_I & RDY_O;
   assign b_eff  = (SUB == ADDP_SUB) ? ~B : B;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int  REM  = WIDTH - k*SEG;
      localparam bit  LAST = (k == STAGES-1);
      // Intermediate stage register layout: {a_hi, b_hi, s_lo, carry}.
      // Final stage register layout:        {ov, co, s}.
      localparam int  DW   = LAST ? WIDTH + 2
                                  : 2*(REM-SEG) + (k+1)*SEG + 1;

      logic [REM-1:0]        a_rem;
      logic [REM-1:0]        b_rem;
      logic                  c_in;
      logic                  v_in;
      logic [(k+1)*SEG-1:0]  s_new;
      logic [SEG-1:0]        seg_s;
      logic                  seg_co;
      logic                  seg_cm;
      logic [DW-1:0]         d_in;
      logic [DW-1:0]         d_q;
      logic                  v_q;

      if (k == 0) begin : g_first
         assign a_rem = A;
         assign b_rem = b_eff;
         assign c_in  = CI;
         assign v_in  = accept;
         assign s_new = seg_s;
      end else begin : g_next
         localparam int LO = k*SEG;
         logic [LO-1:0] s_lo_in;
         assign a_rem   = g_stage[k-1].d_q[2*REM+LO : REM+LO+1];
         assign b_rem   = g_stage[k-1].d_q[REM+LO : LO+1];
         assign s_lo_in = g_stage[k-1].d_q[LO:1];
         assign c_in    = g_stage[k-1].d_q[0];
         assign v_in    = g_stage[k-1].v_q;
         assign s_new   = {seg_s, s_lo_in};
      end

      gf180mcu_osu_sc_12T_addp_seg #(
         .SEG (SEG)
      ) u_seg (
         .a  (a_rem[SEG-1:0]),
         .b  (b_rem[SEG-1:0]),
         .ci (c_in),
         .s  (seg_s),
         .co (seg_co),
         .cm (seg_cm)
      );

      if (LAST) begin : g_last
         assign d_in  = {seg_cm ^ seg_co, seg_co, s_new};
         assign {OV, CO, S} = d_q;
         assign VLD_O = v_q;
      end else begin : g_mid
         logic cm_unused;
         assign cm_unused = seg_cm;
         assign d_in = {a_rem[REM-1:SEG], b_rem[REM-1:SEG], s_new, seg_co};
      end

      // Global stall: nothing moves while RDY_O is low. Data registers only
      // load under a valid token so bubbles leave the last result in place.
      always_ff @(posedge CLK or negedge RN) begin
         if (!RN) begin
            v_q <= 1'b0;
            d_q <= '0;
         end else if (RDY_O) begin
            v_q <= v_in;
            if (v_in) begin
               d_q <= d_in;
            end
         end
      end
   end

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_addp.sv
module tb_gf180mcu_osu_sc_12t_addp;

   logic       CLK = 1'b0;
   logic       RN;
   logic [7:0] A, B, S;
   logic       CI, SUB, VLD_I, RDY_O, CO, OV, VLD_O, RDY_I;
   logic [3:0] A4, B4, S4;
   logic       CI4, SUB4, VLD_I4, RDY_O4, CO4, OV4, VLD_O4, RDY_I4;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   gf180mcu_osu_sc_12t_addp #(.WIDTH(8), .STAGES(2)) dut (
      .CLK(CLK), .RN(RN), .A(A), .B(B), .CI(CI), .SUB(SUB), .VLD_I(VLD_I),
      .RDY_O(RDY_O), .S(S), .CO(CO), .OV(OV), .VLD_O(VLD_O), .RDY_I(RDY_I)
   );

   gf180mcu_osu_sc_12t_addp #(.WIDTH(4), .STAGES(1)) dut4 (
      .CLK(CLK), .RN(RN), .A(A4), .B(B4), .CI(CI4), .SUB(SUB4), .VLD_I(VLD_I4),
      .RDY_O(RDY_O4), .S(S4), .CO(CO4), .OV(OV4), .VLD_O(VLD_O4), .RDY_I(RDY_I4)
   );

   localparam logic [7:0] TA  [6] = '{8'h01, 8'h80, 8'h10, 8'h00, 8'h40, 8'h80};
   localparam logic [7:0] TB  [6] = '{8'h02, 8'h80, 8'h01, 8'h01, 8'h40, 8'h01};
   localparam logic       TS  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
   localparam logic [7:0] ES  [6] = '{8'h03, 8'h00, 8'h0F, 8'hFF, 8'h80, 8'h7F};
   localparam logic       ECO [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
   localparam logic       EOV [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RN = 1'b0; A = '0; B = '0; CI = 0; SUB = 0; VLD_I = 0; RDY_I = 0;
      A4 = '0; B4 = '0; CI4 = 0; SUB4 = 0; VLD_I4 = 0; RDY_I4 = 1;
      #2;
      n_checks++; if (VLD_O !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", VLD_O); end
      n_checks++; if (S !== 8'h00) begin n_fail++; $display("FAIL reset_s: got %h want 00", S); end
      n_checks++; if ({CO, OV} !== 2'b00) begin n_fail++; $display("FAIL reset_co_ov: got %b want 00", {CO, OV}); end
      n_checks++; if (RDY_O !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b want 1", RDY_O); end
      n_checks++; if (VLD_O4 !== 1'b0) begin n_fail++; $display("FAIL reset_vld4: got %b want 0", VLD_O4); end
      step();
      RN = 1'b1;
   endtask

   task automatic test_basic();
      A = 8'hFF; B = 8'h01; CI = 0; SUB = 0; VLD_I = 1; RDY_I = 1;
      step();
      VLD_I = 0;
      n_checks++; if (VLD_O !== 1'b0) begin n_fail++; $display("FAIL basic_latency: got vld %b want 0", VLD_O); end
      step();
      n_checks++; if (VLD_O !== 1'b1) begin n_fail++; $display("FAIL basic_vld: got %b want 1", VLD_O); end
      n_checks++; if (S !== 8'h00) begin n_fail++; $display("FAIL basic_s: got %h want 00", S); end
      n_checks++; if ({CO, OV} !== 2'b10) begin n_fail++; $display("FAIL basic_co_ov: got %b want 10", {CO, OV}); end
      step();
      n_checks++; if (VLD_O !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got vld %b want 0", VLD_O); end
   endtask

   task automatic test_overflow_sub();
      A = 8'h7F; B = 8'h01; CI = 0; SUB = 0; VLD_I = 1; RDY_I = 1;
      step();
      A = 8'h05; B = 8'h07; CI = 1; SUB = 1;
      step();
      VLD_I = 0;
      n_checks++; if ({VLD_O, S} !== {1'b1, 8'h80}) begin n_fail++; $display("FAIL ovf_s: got vld %b s %h want 1 80", VLD_O, S); end
      n_checks++; if ({CO, OV} !== 2'b01) begin n_fail++; $display("FAIL ovf_co_ov: got %b want 01", {CO, OV}); end
      step();
      n_checks++; if ({VLD_O, S} !== {1'b1, 8'hFE}) begin n_fail++; $display("FAIL sub_s: got vld %b s %h want 1 fe", VLD_O, S); end
      n_checks++; if ({CO, OV} !== 2'b00) begin n_fail++; $display("FAIL sub_co_ov: got %b want 00", {CO, OV}); end
      step();
      n_checks++; if ({VLD_O, S} !== {1'b0, 8'hFE}) begin n_fail++; $display("FAIL sub_hold: got vld %b s %h want 0 fe", VLD_O, S); end
   endtask

   task automatic test_back_to_back();
      int  in_idx = 0, out_idx = 0, stall_left = 0, cyc = 0;
      bit  stall_done = 0, acc, cons;
      while (out_idx < 6 && cyc < 40) begin
         VLD_I = (in_idx < 6);
         if (in_idx < 6) begin
            A = TA[in_idx]; B = TB[in_idx]; SUB = TS[in_idx]; CI = TS[in_idx];
         end
         if (VLD_O && !stall_done) begin
            stall_left = 3;
            stall_done = 1;
         end
         RDY_I = (stall_left == 0);
         #1;
         if (VLD_O) begin
            if (out_idx >= 6) begin
               n_checks++; n_fail++; $display("FAIL b2b_extra: got unexpected result %h", S);
            end else begin
               n_checks++;
               if ({S, CO, OV} !== {ES[out_idx], ECO[out_idx], EOV[out_idx]}) begin
                  n_fail++;
                  $display("FAIL b2b_result[%0d]: got s %h co %b ov %b want s %h co %b ov %b",
                           out_idx, S, CO, OV, ES[out_idx], ECO[out_idx], EOV[out_idx]);
               end
            end
            if (!RDY_I) begin
               n_checks++; if (RDY_O !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_rdy: got %b want 0", RDY_O); end
            end
         end
         acc  = VLD_I && RDY_O;
         cons = VLD_O && RDY_I;
         step();
         if (acc) in_idx++;
         if (cons) out_idx++;
         if (stall_left > 0) stall_left--;
         cyc++;
      end
      VLD_I = 0; RDY_I = 1;
      n_checks++; if (out_idx != 6) begin n_fail++; $display("FAIL b2b_count: got %0d results want 6", out_idx); end
      n_checks++; if (stall_done != 1'b1) begin n_fail++; $display("FAIL b2b_stall_seen: got %b want 1", stall_done); end
      #1;
      n_checks++; if (VLD_O !== 1'b0) begin n_fail++; $display("FAIL b2b_dup: got vld %b want 0", VLD_O); end
   endtask

   task automatic test_bubbles();
      logic       vh [8];
      logic [7:0] last_s = 8'h7F;
      logic       exp_v;
      int         tok = 0, outs = 0;
      RDY_I = 1; SUB = 0; CI = 0; B = 8'h20;
      for (int c = 0; c < 8; c++) begin
         VLD_I = (c < 6) && (c % 2 == 0);
         A = 8'(tok + 1);
         #1;
         exp_v = (c >= 2) ? vh[c-2] : 1'b0;
         if (exp_v) begin
            last_s = 8'(8'h21 + outs);
            outs++;
         end
         n_checks++; if (VLD_O !== exp_v) begin n_fail++; $display("FAIL bubble_vld[%0d]: got %b want %b", c, VLD_O, exp_v); end
         n_checks++; if (S !== last_s) begin n_fail++; $display("FAIL bubble_s[%0d]: got %h want %h", c, S, last_s); end
         vh[c] = VLD_I;
         if (VLD_I) tok++;
         step();
      end
      VLD_I = 0;
   endtask

   task automatic test_reset_midflight();
      A = 8'h80; B = 8'h81; CI = 0; SUB = 0; VLD_I = 1; RDY_I = 1;
      step();
      A = 8'h01; B = 8'h01;
      step();
      VLD_I = 0;
      n_checks++; if ({VLD_O, S, CO, OV} !== {1'b1, 8'h01, 1'b1, 1'b1}) begin
         n_fail++; $display("FAIL rst_pre: got vld %b s %h co %b ov %b want 1 01 1 1", VLD_O, S, CO, OV);
      end
      RDY_I = 0;
      #3;
      RN = 1'b0;
      #1;
      n_checks++; if ({VLD_O, S, CO, OV} !== {1'b0, 8'h00, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL rst_async: got vld %b s %h co %b ov %b want 0 00 0 0", VLD_O, S, CO, OV);
      end
      n_checks++; if (RDY_O !== 1'b1) begin n_fail++; $display("FAIL rst_rdy: got %b want 1", RDY_O); end
      step();
      RN = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         n_checks++; if (VLD_O !== 1'b0) begin n_fail++; $display("FAIL rst_ghost[%0d]: got vld %b want 0", c, VLD_O); end
      end
      A = 8'h12; B = 8'h34; VLD_I = 1; RDY_I = 1;
      step();
      VLD_I = 0;
      step();
      n_checks++; if ({VLD_O, S, CO, OV} !== {1'b1, 8'h46, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL rst_after: got vld %b s %h co %b ov %b want 1 46 0 0", VLD_O, S, CO, OV);
      end
   endtask

   task automatic test_w4_single_stage();
      A4 = 4'h9; B4 = 4'h9; CI4 = 1; SUB4 = 0; VLD_I4 = 1; RDY_I4 = 1;
      step();
      A4 = 4'h3; B4 = 4'h5; CI4 = 1; SUB4 = 1;
      n_checks++; if ({VLD_O4, S4, CO4, OV4} !== {1'b1, 4'h3, 1'b1, 1'b1}) begin
         n_fail++; $display("FAIL w4_add: got vld %b s %h co %b ov %b want 1 3 1 1", VLD_O4, S4, CO4, OV4);
      end
      step();
      VLD_I4 = 0;
      n_checks++; if ({VLD_O4, S4, CO4, OV4} !== {1'b1, 4'hE, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL w4_sub: got vld %b s %h co %b ov %b want 1 e 0 0", VLD_O4, S4, CO4, OV4);
      end
      step();
      n_checks++; if ({VLD_O4, S4} !== {1'b0, 4'hE}) begin
         n_fail++; $display("FAIL w4_hold: got vld %b s %h want 0 e", VLD_O4, S4);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow_sub();
      test_back_to_back();
      test_bubbles();
      test_reset_midflight();
      test_w4_single_stage();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
